// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   loader_state_t    : loader FSM state encoding
//   END_WORD_ALL_ONES : all-ones word, sliced to WIDTH for the default terminator
//   clog2             : address-width helper (never returns less than 1)
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TERM,
    ST_WAIT,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

  localparam logic [63:0] END_WORD_ALL_ONES = '1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/loader_mem.sv
// Simple dual-port instruction memory: one write port and one registered read port.
//   clk    : clock
//   reset  : async active-high reset, clears only the read data register
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every edge
//   rdata  : mem[raddr] as of the previous edge (old data on read-during-write)
// The array itself has no reset so it maps onto block RAM.
module loader_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Separate process from the write so a same-address read returns the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: accepts a program as a valid/ready word stream, writes it into the
// instruction memory, appends END_WORD after the last word, waits START_DELAY
// cycles and then raises enable to start the core.
//   clk          : clock
//   reset        : async active-high reset
//   start        : single-cycle pulse, begins or restarts a load from any state
//   in_valid     : stream word valid
//   in_ready     : registered, high while loading
//   in_data      : program word
//   in_last      : final program word marker
//   cpu_addr     : core fetch address
//   cpu_rdata    : fetch data, one cycle latency
//   enable       : run enable to the core
//   busy         : high while loading, terminating or waiting
//   error        : program overflowed the memory; sticky until start or reset
//   loaded_words : number of program words written (terminator excluded)
module program_loader
  import loader_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 1024,
  parameter logic [WIDTH-1:0] END_WORD    = END_WORD_ALL_ONES[WIDTH-1:0],
  parameter int               START_DELAY = 5,
  localparam int              AW          = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [AW-1:0]    cpu_addr,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             enable,
  output logic             busy,
  output logic             error,
  output logic [AW:0]      loaded_words
);

  localparam int          DW        = clog2(START_DELAY + 1);
  localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);

  loader_state_t    state;
  logic [AW:0]      count;
  logic [DW-1:0]    delay;
  logic             accept;
  logic             room;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;

  assign accept       = in_valid & in_ready;
  // The top slot is kept for the terminator, so data may fill only DEPTH-1 words.
  assign room         = (count < LAST_SLOT);
  assign loaded_words = count;

  // A start pulse suppresses any write in its cycle: the restart wins over the beat.
  always_comb begin
    we    = 1'b0;
    waddr = count[AW-1:0];
    wdata = in_data;
    if (!start) begin
      if (state == ST_LOAD && accept && room) begin
        we = 1'b1;
      end else if (state == ST_TERM) begin
        we    = 1'b1;
        wdata = END_WORD;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      delay    <= '0;
      in_ready <= 1'b0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
    end else if (start) begin
      state    <= ST_LOAD;
      count    <= '0;
      in_ready <= 1'b1;
      enable   <= 1'b0;
      busy     <= 1'b1;
      error    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (room) begin
              count <= count + 1'b1;
              if (in_last) begin
                state    <= ST_TERM;
                in_ready <= 1'b0;
              end
            end else begin
              state    <= ST_ERROR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end
          end
        end
        ST_TERM: begin
          // Count down START_DELAY-1..0, so enable rises START_DELAY edges
          // after the terminator write.
          delay <= DW'(START_DELAY - 1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (delay == '0) begin
            state  <= ST_RUN;
            enable <= 1'b1;
            busy   <= 1'b0;
          end else begin
            delay <= delay - DW'(1);
          end
        end
        default: begin
          // IDLE, RUN and ERROR hold until start or reset.
        end
      endcase
    end
  end

  loader_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (cpu_addr),
    .rdata (cpu_rdata)
  );

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import loader_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int SD    = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [2:0] cpu_addr;
  logic [7:0] cpu_rdata;
  logic       enable;
  logic       busy;
  logic       error;
  logic [3:0] loaded_words;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbq [$];

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       last;
  } beat_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp;
  } rd_t;

  beat_t bv [8];
  rd_t   rv [8];

  always #5 clk = ~clk;

  program_loader #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .END_WORD    (8'hFF),
    .START_DELAY (SD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .cpu_addr     (cpu_addr),
    .cpu_rdata    (cpu_rdata),
    .enable       (enable),
    .busy         (busy),
    .error        (error),
    .loaded_words (loaded_words)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    chk("ready_before_beat", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expected word is queued when the address is driven and checked when the
  // registered read data appears.
  task automatic rd(input logic [2:0] a, input logic [7:0] e);
    cpu_addr = a;
    sbq.push_back(e);
    step();
    chk($sformatf("rdata_addr%0d", a), {24'd0, cpu_rdata}, {24'd0, sbq.pop_front()});
  endtask

  task automatic wait_enable(input int maxc);
    int n;
    n = 0;
    while (!enable && n < maxc) begin
      step();
      n++;
    end
    chk("enable_within_budget", {31'd0, enable}, 32'd1);
  endtask

  // Exact-latency check: enable must stay low for SD edges after the last
  // accept and be high on the (SD+1)th.
  task automatic check_rise();
    for (int k = 1; k <= SD + 1; k++) begin
      step();
      chk($sformatf("enable_edge%0d", k), {31'd0, enable}, (k == SD + 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    cpu_addr = 3'd0;

    // ---------------- reset state
    #3;
    chk("rst_in_ready", {31'd0, in_ready}, 0);
    chk("rst_enable", {31'd0, enable}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_error", {31'd0, error}, 0);
    chk("rst_loaded", {28'd0, loaded_words}, 0);
    chk("rst_rdata", {24'd0, cpu_rdata}, 0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 0);

    // ---------------- load 4 words, gapless
    bv[0] = '{8'h10, 1'b1, 1'b0};
    bv[1] = '{8'h20, 1'b1, 1'b0};
    bv[2] = '{8'h30, 1'b1, 1'b0};
    bv[3] = '{8'h40, 1'b1, 1'b1};
    pulse_start();
    chk("t1_ready_after_start", {31'd0, in_ready}, 1);
    chk("t1_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 4; i++) send(bv[i].data, bv[i].last);
    chk("t1_loaded", {28'd0, loaded_words}, 4);
    chk("t1_ready_term", {31'd0, in_ready}, 0);
    chk("t1_busy_term", {31'd0, busy}, 1);
    check_rise();
    chk("t1_busy_run", {31'd0, busy}, 0);
    rv[0] = '{3'd0, 8'h10};
    rv[1] = '{3'd1, 8'h20};
    rv[2] = '{3'd2, 8'h30};
    rv[3] = '{3'd3, 8'h40};
    rv[4] = '{3'd4, 8'hFF};
    for (int i = 0; i < 5; i++) rd(rv[i].addr, rv[i].exp);
    chk("t1_loaded_hold", {28'd0, loaded_words}, 4);

    // ---------------- gapped stream, 3 words with idle beats in between
    bv[0] = '{8'h51, 1'b1, 1'b0};
    bv[1] = '{8'hEE, 1'b0, 1'b1};
    bv[2] = '{8'h52, 1'b1, 1'b0};
    bv[3] = '{8'hEE, 1'b0, 1'b1};
    bv[4] = '{8'h53, 1'b1, 1'b1};
    pulse_start();
    chk("t2_enable_drop", {31'd0, enable}, 0);
    for (int i = 0; i < 5; i++) begin
      if (bv[i].valid) begin
        send(bv[i].data, bv[i].last);
      end else begin
        in_valid = 1'b0;
        in_data  = bv[i].data;
        in_last  = bv[i].last;
        step();
        in_last  = 1'b0;
      end
    end
    chk("t2_loaded", {28'd0, loaded_words}, 3);
    wait_enable(20);
    rv[0] = '{3'd0, 8'h51};
    rv[1] = '{3'd1, 8'h52};
    rv[2] = '{3'd2, 8'h53};
    rv[3] = '{3'd3, 8'hFF};
    rv[4] = '{3'd4, 8'hFF};
    for (int i = 0; i < 5; i++) rd(rv[i].addr, rv[i].exp);

    // ---------------- start coincident with a beat: beat dropped
    pulse_start();
    in_valid = 1'b1;
    in_data  = 8'h99;
    in_last  = 1'b1;
    start    = 1'b1;
    step();
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t2b_beat_dropped", {28'd0, loaded_words}, 0);
    chk("t2b_still_loading", {31'd0, in_ready}, 1);
    rd(3'd0, 8'h51);

    // ---------------- overflow: 8 beats into DEPTH=8 without in_last
    pulse_start();
    for (int i = 0; i < 7; i++) send(8'h60 + 8'(i), 1'b0);
    chk("t3_loaded7", {28'd0, loaded_words}, 7);
    chk("t3_ready7", {31'd0, in_ready}, 1);
    send(8'h67, 1'b0);
    chk("t3_error", {31'd0, error}, 1);
    chk("t3_ready", {31'd0, in_ready}, 0);
    chk("t3_enable", {31'd0, enable}, 0);
    chk("t3_busy", {31'd0, busy}, 0);
    chk("t3_loaded_hold", {28'd0, loaded_words}, 7);
    for (int i = 0; i < 7; i++) rd(3'(i), 8'h60 + 8'(i));
    chk("t3_error_sticky", {31'd0, error}, 1);
    pulse_start();
    chk("t3_error_cleared", {31'd0, error}, 0);
    chk("t3_ready_again", {31'd0, in_ready}, 1);

    // ---------------- 0x11,0x22 then fetch in RUN
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    wait_enable(20);
    rd(3'd1, 8'h22);
    rd(3'd2, 8'hFF);
    rd(3'd3, 8'h63);

    // ---------------- restart from RUN, load AA,BB
    pulse_start();
    chk("t4_enable_drop", {31'd0, enable}, 0);
    chk("t4_loaded_zero", {28'd0, loaded_words}, 0);
    // Write to addr 0 while reading it: old word must come back.
    cpu_addr = 3'd0;
    send(8'hAA, 1'b0);
    chk("t4_read_during_write", {24'd0, cpu_rdata}, 32'h11);
    send(8'hBB, 1'b1);
    check_rise();
    rd(3'd0, 8'hAA);
    rd(3'd1, 8'hBB);
    rd(3'd2, 8'hFF);

    // ---------------- reset during WAIT
    begin
      logic seen_en;
      pulse_start();
      send(8'h77, 1'b1);
      step();
      step();
      chk("t5_in_wait", 32'(dut.state), 32'(ST_WAIT));
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_enable", {31'd0, enable}, 0);
      chk("t5_async_busy", {31'd0, busy}, 0);
      chk("t5_async_ready", {31'd0, in_ready}, 0);
      chk("t5_async_error", {31'd0, error}, 0);
      chk("t5_async_loaded", {28'd0, loaded_words}, 0);
      chk("t5_async_rdata", {24'd0, cpu_rdata}, 0);
      step();
      #2;
      reset = 1'b0;
      seen_en = 1'b0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (enable) seen_en = 1'b1;
      end
      chk("t5_enable_never", {31'd0, seen_en}, 0);
      chk("t5_state_idle", 32'(dut.state), 32'(ST_IDLE));
      chk("t5_busy_idle", {31'd0, busy}, 0);
      rd(3'd0, 8'h77);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
